// File: rtl/vpll_mif_sequencer_if.sv
// Avalon-MM management port between the MIF sequencer (master)
// and the video-PLL reconfiguration controller (slave).
interface vpll_mif_sequencer_if;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;

  modport master (
    output mgmt_write,
    output mgmt_address,
    output mgmt_writedata,
    input  mgmt_waitrequest
  );

  modport slave (
    input  mgmt_write,
    input  mgmt_address,
    input  mgmt_writedata,
    output mgmt_waitrequest
  );
endinterface

// File: rtl/vpll_mif_sequencer.sv
// Follows the VIDC base-clock select by reprogramming the video PLL through its
// reconfig controller: MIF base write, start write, then wait for busy/relock.
module vpll_mif_sequencer #(
  parameter int unsigned STABLE_CYCLES   = 16,
  parameter logic [5:0]  MIF_ADDR_REG    = 6'd31,
  parameter logic [5:0]  START_REG       = 6'd2,
  parameter int unsigned MIF_STRIDE_LOG2 = 6,
  parameter logic [19:0] LOCK_TIMEOUT    = 20'd500000
) (
  input  logic                        CLK_50M,
  input  logic                        reset,
  input  logic [1:0]                  sel_in,
  input  logic                        pll_locked,
  vpll_mif_sequencer_if.master        mgmt,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout_err,
  output logic [1:0]                  active_sel
);

  localparam int unsigned      CNT_W      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WR_MIF    = 3'd1;
  localparam logic [2:0] ST_GAP1      = 3'd2;
  localparam logic [2:0] ST_WR_START  = 3'd3;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd4;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  localparam logic [19:0] BUSY_WAIT_LAST = 20'd3;

  logic [1:0]       sel_meta_q, sel_meta_d;
  logic [1:0]       sel_s_q, sel_s_d;
  logic             lock_meta_q, lock_meta_d;
  logic             lock_s_q, lock_s_d;
  logic [CNT_W-1:0] stab_q, stab_d;
  logic [1:0]       cand_q, cand_d;
  logic             cand_valid_q, cand_valid_d;
  logic             pending_q, pending_d;
  logic [1:0]       active_q, active_d;
  logic [2:0]       state_q, state_d;
  logic [19:0]      tmr_q, tmr_d;
  logic             err_q, err_d;
  logic             accept;

  always_comb begin
    sel_meta_d   = sel_in;
    sel_s_d      = sel_meta_q;
    lock_meta_d  = pll_locked;
    lock_s_d     = lock_meta_q;
    stab_d       = stab_q;
    cand_d       = cand_q;
    cand_valid_d = cand_valid_q;
    pending_d    = pending_q;
    active_d     = active_q;
    state_d      = state_q;
    tmr_d        = tmr_q;
    err_d        = err_q;
    accept       = 1'b0;

    // Clearing on the edge sel_s takes a new value makes stab_q the number of
    // cycles sel_s has held, so a select is accepted 2 + STABLE_CYCLES after it changes.
    if (sel_meta_q != sel_s_q) begin
      stab_d = '0;
    end else if (stab_q != STABLE_MAX) begin
      stab_d = stab_q + CNT_W'(1);
      accept = (stab_d == STABLE_MAX);
    end

    case (state_q)
      ST_IDLE: begin
        if (pending_q && cand_valid_q) begin
          active_d  = cand_q;
          pending_d = 1'b0;
          state_d   = ST_WR_MIF;
        end
      end
      ST_WR_MIF: begin
        if (!mgmt.mgmt_waitrequest) state_d = ST_GAP1;
      end
      ST_GAP1: begin
        state_d = ST_WR_START;
      end
      ST_WR_START: begin
        if (!mgmt.mgmt_waitrequest) begin
          state_d = ST_WAIT_BUSY;
          tmr_d   = '0;
        end
      end
      ST_WAIT_BUSY: begin
        if (mgmt.mgmt_waitrequest || tmr_q == BUSY_WAIT_LAST) begin
          state_d = ST_WAIT_LOCK;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 20'd1;
        end
      end
      ST_WAIT_LOCK: begin
        if (!mgmt.mgmt_waitrequest && lock_s_q) begin
          state_d = ST_DONE;
          tmr_d   = '0;
        end else if (tmr_q + 20'd1 == LOCK_TIMEOUT) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 20'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Until the first select is accepted the reset-forced pending must survive,
    // even when that select matches the reset active_sel.
    if (accept) begin
      cand_d       = sel_s_q;
      cand_valid_d = 1'b1;
      pending_d    = !cand_valid_q || (sel_s_q != active_d);
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      sel_meta_q   <= '0;
      sel_s_q      <= '0;
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
      stab_q       <= '0;
      cand_q       <= '0;
      cand_valid_q <= 1'b0;
      pending_q    <= 1'b1;
      active_q     <= '0;
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      sel_meta_q   <= sel_meta_d;
      sel_s_q      <= sel_s_d;
      lock_meta_q  <= lock_meta_d;
      lock_s_q     <= lock_s_d;
      stab_q       <= stab_d;
      cand_q       <= cand_d;
      cand_valid_q <= cand_valid_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      err_q        <= err_d;
    end
  end

  // Bus outputs decode straight from state, so they hold while stalled.
  always_comb begin
    mgmt.mgmt_write     = 1'b0;
    mgmt.mgmt_address   = '0;
    mgmt.mgmt_writedata = '0;
    case (state_q)
      ST_WR_MIF: begin
        mgmt.mgmt_write     = 1'b1;
        mgmt.mgmt_address   = MIF_ADDR_REG;
        mgmt.mgmt_writedata = 32'(active_q) << MIF_STRIDE_LOG2;
      end
      ST_WR_START: begin
        mgmt.mgmt_write   = 1'b1;
        mgmt.mgmt_address = START_REG;
      end
      default: begin
        mgmt.mgmt_write = 1'b0;
      end
    endcase
  end

  assign busy        = (state_q != ST_IDLE) || pending_q;
  assign done        = (state_q == ST_DONE);
  assign timeout_err = err_q;
  assign active_sel  = active_q;

endmodule

// File: tb/tb_vpll_mif_sequencer.sv
// Directed bench for vpll_mif_sequencer: a small reconfig-IP model logs accepted
// writes and done pulses, and each scenario is checked against hand-computed values.
module tb_vpll_mif_sequencer;

  logic       CLK_50M;
  logic       reset;
  logic [1:0] sel_in;
  logic       pll_locked;
  logic       busy;
  logic       done;
  logic       timeout_err;
  logic [1:0] active_sel;

  vpll_mif_sequencer_if mgmt_bus ();

  vpll_mif_sequencer #(
    .STABLE_CYCLES   (16),
    .MIF_ADDR_REG    (6'd31),
    .START_REG       (6'd2),
    .MIF_STRIDE_LOG2 (6),
    .LOCK_TIMEOUT    (20'd100)
  ) dut (
    .CLK_50M     (CLK_50M),
    .reset       (reset),
    .sel_in      (sel_in),
    .pll_locked  (pll_locked),
    .mgmt        (mgmt_bus.master),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .active_sel  (active_sel)
  );

  initial CLK_50M = 1'b0;
  always #10 CLK_50M = ~CLK_50M;

  int vectors;
  int miscompares;
  int cyc;
  int base;
  int ip_busy_cnt;
  int stall_mif;
  int stall_first_cyc;
  int stall_cycles;
  int stall_bad;
  int err_rise_cyc;
  logic [31:0] stall_data_exp;
  logic [5:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          done_cyc_q[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock: the IP model drives waitrequest for this cycle, then accepted
  // writes, done pulses and the timeout edge are logged.
  task automatic advanceCycle();
    @(posedge CLK_50M);
    #1;
    cyc++;
    if (ip_busy_cnt > 0) begin
      mgmt_bus.mgmt_waitrequest = 1'b1;
      ip_busy_cnt--;
    end else if (stall_mif > 0 && mgmt_bus.mgmt_write === 1'b1 && mgmt_bus.mgmt_address === 6'd31) begin
      mgmt_bus.mgmt_waitrequest = 1'b1;
      stall_mif--;
      if (stall_first_cyc < 0) stall_first_cyc = cyc;
      stall_cycles++;
      if (mgmt_bus.mgmt_writedata !== stall_data_exp) stall_bad++;
    end else begin
      mgmt_bus.mgmt_waitrequest = 1'b0;
    end
    #1;
    if (mgmt_bus.mgmt_write === 1'b1 && mgmt_bus.mgmt_waitrequest === 1'b0) begin
      wr_addr_q.push_back(mgmt_bus.mgmt_address);
      wr_data_q.push_back(mgmt_bus.mgmt_writedata);
      wr_cyc_q.push_back(cyc);
      if (mgmt_bus.mgmt_address === 6'd2) ip_busy_cnt = 10;
    end
    if (done === 1'b1) done_cyc_q.push_back(cyc);
    if (timeout_err === 1'b1 && err_rise_cyc < 0) err_rise_cyc = cyc;
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) advanceCycle();
  endtask

  task automatic clearLogs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    cyc             = 0;
    ip_busy_cnt     = 0;
    stall_mif       = 0;
    stall_first_cyc = -1;
    stall_cycles    = 0;
    stall_bad       = 0;
    err_rise_cyc    = -1;
    stall_data_exp  = 32'd0;
    reset           = 1'b1;
    sel_in          = 2'd2;
    pll_locked      = 1'b1;
    mgmt_bus.mgmt_waitrequest = 1'b0;

    // Reset values
    applyStimulus(2);
    checkOutput("rst_write", 32'(mgmt_bus.mgmt_write), 32'd0);
    checkOutput("rst_addr", 32'(mgmt_bus.mgmt_address), 32'd0);
    checkOutput("rst_data", mgmt_bus.mgmt_writedata, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(timeout_err), 32'd0);
    checkOutput("rst_active", 32'(active_sel), 32'd0);

    // First sequence: sel 2, writes at base+19 / base+21, done at base+33
    reset = 1'b0;
    base  = cyc;
    clearLogs();
    applyStimulus(40);
    checkOutput("t1_nwr", 32'(wr_addr_q.size()), 32'd2);
    checkOutput("t1_addr0", 32'(wr_addr_q[0]), 32'd31);
    checkOutput("t1_data0", wr_data_q[0], 32'h80);
    checkOutput("t1_cyc0", 32'(wr_cyc_q[0] - base), 32'd19);
    checkOutput("t1_addr1", 32'(wr_addr_q[1]), 32'd2);
    checkOutput("t1_data1", wr_data_q[1], 32'h0);
    checkOutput("t1_cyc1", 32'(wr_cyc_q[1] - base), 32'd21);
    checkOutput("t1_ndone", 32'(done_cyc_q.size()), 32'd1);
    checkOutput("t1_done_cyc", 32'(done_cyc_q[0] - base), 32'd33);
    checkOutput("t1_busy", 32'(busy), 32'd0);
    checkOutput("t1_active", 32'(active_sel), 32'd2);

    // Toggling 1<->3 every 5 cycles never settles; then 3 held
    clearLogs();
    for (int i = 0; i < 20; i++) begin
      sel_in = (i % 2 == 0) ? 2'd1 : 2'd3;
      applyStimulus(5);
    end
    checkOutput("t2_no_wr_toggle", 32'(wr_addr_q.size()), 32'd0);
    applyStimulus(80);
    checkOutput("t2_nwr", 32'(wr_addr_q.size()), 32'd2);
    checkOutput("t2_data0", wr_data_q[0], 32'hC0);
    checkOutput("t2_addr1", 32'(wr_addr_q[1]), 32'd2);
    checkOutput("t2_ndone", 32'(done_cyc_q.size()), 32'd1);
    checkOutput("t2_active", 32'(active_sel), 32'd3);

    // Waitrequest stalls the MIF write for 7 cycles
    clearLogs();
    stall_mif      = 7;
    stall_data_exp = 32'h40;
    sel_in         = 2'd1;
    applyStimulus(60);
    checkOutput("t3_stall_cycles", 32'(stall_cycles), 32'd7);
    checkOutput("t3_stall_hold", 32'(stall_bad), 32'd0);
    checkOutput("t3_nwr", 32'(wr_addr_q.size()), 32'd2);
    checkOutput("t3_addr0", 32'(wr_addr_q[0]), 32'd31);
    checkOutput("t3_data0", wr_data_q[0], 32'h40);
    checkOutput("t3_accept_cyc", 32'(wr_cyc_q[0] - stall_first_cyc), 32'd7);
    checkOutput("t3_start_gap", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'd2);
    checkOutput("t3_ndone", 32'(done_cyc_q.size()), 32'd1);

    // Select change 2->1 while waiting for lock is queued, not aborting
    clearLogs();
    sel_in     = 2'd2;
    pll_locked = 1'b0;
    applyStimulus(35);
    sel_in = 2'd1;
    applyStimulus(25);
    checkOutput("t4_no_abort_nwr", 32'(wr_addr_q.size()), 32'd2);
    checkOutput("t4_busy_held", 32'(busy), 32'd1);
    pll_locked = 1'b1;
    applyStimulus(60);
    checkOutput("t4_nwr", 32'(wr_addr_q.size()), 32'd4);
    checkOutput("t4_data0", wr_data_q[0], 32'h80);
    checkOutput("t4_data2", wr_data_q[2], 32'h40);
    checkOutput("t4_addr3", 32'(wr_addr_q[3]), 32'd2);
    checkOutput("t4_ndone", 32'(done_cyc_q.size()), 32'd2);
    checkOutput("t4_order", 32'(done_cyc_q[0] < wr_cyc_q[2]), 32'd1);
    checkOutput("t4_active", 32'(active_sel), 32'd1);

    // Lock never arrives: timeout 100 cycles into WAIT_LOCK (start write + 102)
    clearLogs();
    sel_in       = 2'd3;
    pll_locked   = 1'b0;
    err_rise_cyc = -1;
    applyStimulus(200);
    checkOutput("t5_nwr", 32'(wr_addr_q.size()), 32'd2);
    checkOutput("t5_data0", wr_data_q[0], 32'hC0);
    checkOutput("t5_err", 32'(timeout_err), 32'd1);
    checkOutput("t5_err_cyc", 32'(err_rise_cyc - wr_cyc_q[1]), 32'd102);
    checkOutput("t5_ndone", 32'(done_cyc_q.size()), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_active", 32'(active_sel), 32'd3);

    // Reset while the MIF write is stalled, then full rerun with sel 0
    clearLogs();
    pll_locked      = 1'b1;
    sel_in          = 2'd0;
    stall_mif       = 100;
    stall_data_exp  = 32'h0;
    stall_cycles    = 0;
    stall_bad       = 0;
    stall_first_cyc = -1;
    for (int i = 0; i < 60 && stall_cycles < 2; i++) advanceCycle();
    checkOutput("t6_write_seen", 32'(stall_cycles >= 2), 32'd1);
    reset     = 1'b1;
    stall_mif = 0;
    advanceCycle();
    checkOutput("t6_rst_write", 32'(mgmt_bus.mgmt_write), 32'd0);
    checkOutput("t6_rst_addr", 32'(mgmt_bus.mgmt_address), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd1);
    checkOutput("t6_rst_err", 32'(timeout_err), 32'd0);
    checkOutput("t6_rst_active", 32'(active_sel), 32'd0);
    reset = 1'b0;
    base  = cyc;
    clearLogs();
    applyStimulus(40);
    checkOutput("t6_nwr", 32'(wr_addr_q.size()), 32'd2);
    checkOutput("t6_addr0", 32'(wr_addr_q[0]), 32'd31);
    checkOutput("t6_data0", wr_data_q[0], 32'h0);
    checkOutput("t6_cyc0", 32'(wr_cyc_q[0] - base), 32'd17);
    checkOutput("t6_cyc1", 32'(wr_cyc_q[1] - base), 32'd19);
    checkOutput("t6_done_cyc", 32'(done_cyc_q[0] - base), 32'd31);
    checkOutput("t6_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
